// File: rtl/booth_arb_pkg.sv
// ---------------------------------------------------------------------------
// booth_arb_pkg
// Shared definitions for the Booth multiplier arbiter:
//   - state_e : controller states (IDLE, ISSUE, BUSY, RESP)
//   - MODE_*  : sign_mode encodings (bit1 = A signed, bit0 = B signed)
//   - idw()   : requester ID width, max(1, clog2(n))
// ---------------------------------------------------------------------------
package booth_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_US = 2'b01;
  localparam logic [1:0] MODE_SU = 2'b10;
  localparam logic [1:0] MODE_SS = 2'b11;

  // A single requester still needs a 1-bit ID field, so clamp to 1.
  function automatic int idw(input int n);
    if (n <= 2) begin
      return 1;
    end
    return $clog2(n);
  endfunction

endpackage

// File: rtl/booth_rr_pick.sv
// ---------------------------------------------------------------------------
// booth_rr_pick
// Combinational round-robin priority picker. The winner is the first
// asserted valid bit at or above ptr_i, wrapping around to bit 0.
// Ports:
//   valid_i [NUM_REQ] : request vector
//   ptr_i   [IDW]     : highest-priority index for this pick
//   grant_o [NUM_REQ] : one-hot grant, zero when nothing is valid
//   idx_o   [IDW]     : binary index of the granted bit
//   any_o             : at least one request is valid
// ---------------------------------------------------------------------------
module booth_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDW-1:0]     idx_o,
  output logic               any_o
);

  // Two passes avoid a modulo on a variable index: first the upper segment
  // starting at the pointer, then the wrapped-around lower segment.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && valid_i[k] && (k >= int'(ptr_i))) begin
        any_o      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = IDW'(k);
      end
    end
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && valid_i[k] && (k < int'(ptr_i))) begin
        any_o      = 1'b1;
        grant_o[k] = 1'b1;
        idx_o      = IDW'(k);
      end
    end
  end

endmodule

// File: rtl/booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// booth_mult_arbiter
// Round-robin controller sharing one 8-bit Booth multiplier core between
// NUM_REQ requesters. One operand set is accepted at a time, the core gets
// a single-cycle start pulse, and the product is returned on a shared
// response channel tagged with the requester ID.
//
// Build option: define BOOTH_ARB_TIMEOUT_EN to abort a core operation that
// has not signalled done after TIMEOUT_CYC BUSY cycles (rsp_err=1,
// rsp_product=0). Without it rsp_err is tied 0 and BUSY waits forever.
//
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   req_valid/ready    : per-requester operand handshake (ready one-hot/zero)
//   req_a/req_b        : packed 8-bit operands, requester k at [8k+7:8k]
//   req_mode           : packed 2-bit sign modes, requester k at [2k+1:2k]
//   rsp_valid/ready    : response handshake
//   rsp_product/id/err : response payload
//   mul_start/a/b/mode : command to the multiplier core
//   mul_product/done   : result from the multiplier core
// ---------------------------------------------------------------------------
module booth_mult_arbiter
  import booth_arb_pkg::*;
#(
  parameter  int NUM_REQ     = 4,
  parameter  int TIMEOUT_CYC = 64,
  localparam int IDW         = idw(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [8*NUM_REQ-1:0] req_a,
  input  logic [8*NUM_REQ-1:0] req_b,
  input  logic [2*NUM_REQ-1:0] req_mode,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [15:0]          rsp_product,
  output logic [IDW-1:0]       rsp_id,
  output logic                 rsp_err,
  output logic                 mul_start,
  output logic [7:0]           mul_a,
  output logic [7:0]           mul_b,
  output logic [1:0]           mul_mode,
  input  logic [15:0]          mul_product,
  input  logic                 mul_done
);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("booth_mult_arbiter: NUM_REQ must be 2..16 and TIMEOUT_CYC >= 1");
  end

  state_e           state_q, state_d;
  logic [IDW-1:0]   rrPtr_q, rrPtr_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [7:0]       mulA_q, mulA_d;
  logic [7:0]       mulB_q, mulB_d;
  logic [1:0]       mulMode_q, mulMode_d;
  logic [15:0]      rspProduct_q, rspProduct_d;

  logic [NUM_REQ-1:0] pickGrant;
  logic [IDW-1:0]     pickIdx;
  logic               pickAny;

  logic [7:0] reqA    [NUM_REQ];
  logic [7:0] reqB    [NUM_REQ];
  logic [1:0] reqMode [NUM_REQ];

  // Unpack the flat operand buses so the winner can be selected by index.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign reqA[k]    = req_a[8*k +: 8];
    assign reqB[k]    = req_b[8*k +: 8];
    assign reqMode[k] = req_mode[2*k +: 2];
  end

  booth_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_pick (
    .valid_i (req_valid),
    .ptr_i   (rrPtr_q),
    .grant_o (pickGrant),
    .idx_o   (pickIdx),
    .any_o   (pickAny)
  );

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int CNTW = $clog2(TIMEOUT_CYC + 1);

  logic [CNTW-1:0] tmoCnt_q, tmoCnt_d;
  logic            rspErr_q, rspErr_d;
  logic            timeoutHit;

  // The counter holds the number of BUSY cycles already completed, so the
  // abort fires during the TIMEOUT_CYC-th BUSY cycle.
  assign timeoutHit = (tmoCnt_q == CNTW'(TIMEOUT_CYC - 1));
`endif

  // State register and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      rrPtr_q      <= '0;
      id_q         <= '0;
      mulA_q       <= '0;
      mulB_q       <= '0;
      mulMode_q    <= '0;
      rspProduct_q <= '0;
`ifdef BOOTH_ARB_TIMEOUT_EN
      tmoCnt_q     <= '0;
      rspErr_q     <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      rrPtr_q      <= rrPtr_d;
      id_q         <= id_d;
      mulA_q       <= mulA_d;
      mulB_q       <= mulB_d;
      mulMode_q    <= mulMode_d;
      rspProduct_q <= rspProduct_d;
`ifdef BOOTH_ARB_TIMEOUT_EN
      tmoCnt_q     <= tmoCnt_d;
      rspErr_q     <= rspErr_d;
`endif
    end
  end

  // Next-state logic. In IDLE a valid winner always sees its ready, so the
  // request handshake is simply pickAny. mul_done outside BUSY is ignored
  // because only the BUSY branch looks at it.
  always_comb begin
    state_d      = state_q;
    rrPtr_d      = rrPtr_q;
    id_d         = id_q;
    mulA_d       = mulA_q;
    mulB_d       = mulB_q;
    mulMode_d    = mulMode_q;
    rspProduct_d = rspProduct_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
    tmoCnt_d     = tmoCnt_q;
    rspErr_d     = rspErr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pickAny) begin
          mulA_d    = reqA[pickIdx];
          mulB_d    = reqB[pickIdx];
          mulMode_d = reqMode[pickIdx];
          id_d      = pickIdx;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
`ifdef BOOTH_ARB_TIMEOUT_EN
        tmoCnt_d = '0;
`endif
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        if (mul_done) begin
          rspProduct_d = mul_product;
`ifdef BOOTH_ARB_TIMEOUT_EN
          rspErr_d     = 1'b0;
`endif
          state_d      = ST_RESP;
        end
`ifdef BOOTH_ARB_TIMEOUT_EN
        else if (timeoutHit) begin
          rspProduct_d = '0;
          rspErr_d     = 1'b1;
          state_d      = ST_RESP;
        end else begin
          tmoCnt_d = tmoCnt_q + 1'b1;
        end
`endif
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rrPtr_d = (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode. req_ready is gated by rst so no requester believes it
  // was accepted during a reset cycle.
  always_comb begin
    req_ready = '0;
    mul_start = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      ST_IDLE:  req_ready = rst ? '0 : pickGrant;
      ST_ISSUE: mul_start = 1'b1;
      ST_BUSY:  ;
      ST_RESP:  rsp_valid = 1'b1;
      default:  ;
    endcase
  end

  assign mul_a       = mulA_q;
  assign mul_b       = mulB_q;
  assign mul_mode    = mulMode_q;
  assign rsp_product = rspProduct_q;
  assign rsp_id      = id_q;
`ifdef BOOTH_ARB_TIMEOUT_EN
  assign rsp_err     = rspErr_q;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_arbiter
// Self-checking bench for booth_mult_arbiter. The bench plays both the
// requesters and the multiplier core; expected products come from plain
// integer arithmetic on the operands each requester sent, expected grants
// from the round-robin rule. Timeout checks compile only when
// BOOTH_ARB_TIMEOUT_EN is defined.
// ---------------------------------------------------------------------------
module tb_booth_mult_arbiter;
  import booth_arb_pkg::*;

  localparam int NUM_REQ     = 4;
  localparam int TIMEOUT_CYC = 64;
  localparam int IDW         = idw(NUM_REQ);

  logic                 clk;
  logic                 rst;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [8*NUM_REQ-1:0] req_a;
  logic [8*NUM_REQ-1:0] req_b;
  logic [2*NUM_REQ-1:0] req_mode;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [15:0]          rsp_product;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_err;
  logic                 mul_start;
  logic [7:0]           mul_a;
  logic [7:0]           mul_b;
  logic [1:0]           mul_mode;
  logic [15:0]          mul_product;
  logic                 mul_done;

  booth_mult_arbiter #(
    .NUM_REQ     (NUM_REQ),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_mode    (req_mode),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_product (rsp_product),
    .rsp_id      (rsp_id),
    .rsp_err     (rsp_err),
    .mul_start   (mul_start),
    .mul_a       (mul_a),
    .mul_b       (mul_b),
    .mul_mode    (mul_mode),
    .mul_product (mul_product),
    .mul_done    (mul_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         id;
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] mode;
    int         lat;
  } job_t;

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  mode;
    int          lat;
    logic [15:0] prod;
    logic        err;
    int          expLat;
  } txn_t;

  typedef struct {
    int          id;
    logic [15:0] prod;
    logic        err;
    int          waited;
  } rsp_t;

  typedef struct {
    int          id;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [1:0]  mode;
    int          lat;
    int          hold;
    logic [15:0] expProd;
  } vec_t;

  job_t pendQ[$];
  txn_t expQ[$];
  rsp_t rspLog[$];

  int testsRun    = 0;
  int testsFailed = 0;
  int modelPtr    = 0;
  bit modelBusy   = 0;
  int cd          = 0;
  int startCount  = 0;
  int startCycle  = 0;
  int cycleCount  = 0;
  int rspCycles   = 0;
  bit rspSeen     = 0;
  int holdLeft    = 0;
  bit randomReady = 0;
  bit randomDrop  = 0;
  bit coreMute    = 0;

  // Reference multiply: extend each operand per its sign bit, multiply as
  // integers, keep the low 16 bits.
  function automatic logic [15:0] refProduct(logic [7:0] a, logic [7:0] b, logic [1:0] mode);
    int av, bv, p;
    av = mode[1] ? int'($signed(a)) : int'(a);
    bv = mode[0] ? int'($signed(b)) : int'(b);
    p  = av * bv;
    return p[15:0];
  endfunction

  // Round-robin rule: first valid requester at or after ptr, wrapping.
  function automatic int expectWinner(logic [NUM_REQ-1:0] v, int ptr);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
    end
    return -1;
  endfunction

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic void pushJob(int id, logic [7:0] a, logic [7:0] b, logic [1:0] mode, int lat);
    job_t j;
    j.id = id; j.a = a; j.b = b; j.mode = mode; j.lat = lat;
    pendQ.push_back(j);
  endfunction

  // One clock cycle of requesters, core model and response consumer, all
  // acting at the falling edge so DUT outputs are stable when read.
  task automatic applyStimulus();
    logic [NUM_REQ-1:0] v;
    logic [NUM_REQ-1:0] expReady;
    int w;
    bit handshake;
    @(negedge clk);
    cycleCount++;

    mul_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0 && !coreMute) begin
        mul_done    = 1'b1;
        mul_product = refProduct(mul_a, mul_b, mul_mode);
      end
    end
    if (mul_start) begin
      startCount++;
      checkOutput("txn_in_flight_at_start", expQ.size(), 1);
      if (expQ.size() > 0) begin
        checkOutput("mul_a", mul_a, expQ[0].a);
        checkOutput("mul_b", mul_b, expQ[0].b);
        checkOutput("mul_mode", mul_mode, expQ[0].mode);
        cd         = expQ[0].lat;
        startCycle = cycleCount;
      end
    end

    v = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = -1;
      for (int q = 0; q < pendQ.size(); q++) begin
        if (j < 0 && pendQ[q].id == k) j = q;
      end
      if (j >= 0 && !(randomDrop && $urandom_range(0, 3) == 0)) begin
        v[k]              = 1'b1;
        req_a[8*k +: 8]   = pendQ[j].a;
        req_b[8*k +: 8]   = pendQ[j].b;
        req_mode[2*k +: 2] = pendQ[j].mode;
      end
    end
    req_valid = v;
    #1;

    w = modelBusy ? -1 : expectWinner(v, modelPtr);
    expReady = '0;
    if (w >= 0) expReady[w] = 1'b1;
    checkOutput("req_ready", req_ready, expReady);

    handshake = 1'b0;
    if (rsp_valid) begin
      rspCycles++;
      checkOutput("txn_in_flight_at_rsp", expQ.size(), 1);
      if (expQ.size() > 0) begin
        checkOutput("rsp_product", rsp_product, expQ[0].prod);
        checkOutput("rsp_id", rsp_id, expQ[0].id);
        checkOutput("rsp_err", rsp_err, expQ[0].err);
        if (!rspSeen) begin
          rspSeen = 1'b1;
          checkOutput("rsp_latency", cycleCount - startCycle, expQ[0].expLat);
        end
        if (holdLeft > 0) holdLeft--;
        else if (!(randomReady && $urandom_range(0, 2) == 0)) handshake = 1'b1;
      end
    end
    rsp_ready = handshake;

    if (w >= 0) begin
      for (int q = 0; q < pendQ.size(); q++) begin
        if (pendQ[q].id == w) begin
          txn_t t;
          t.id = w; t.a = pendQ[q].a; t.b = pendQ[q].b; t.mode = pendQ[q].mode;
          t.lat = pendQ[q].lat;
          if (coreMute) begin
            t.prod = '0; t.err = 1'b1; t.expLat = TIMEOUT_CYC + 1;
          end else begin
            t.prod = refProduct(t.a, t.b, t.mode); t.err = 1'b0; t.expLat = t.lat + 1;
          end
          expQ.push_back(t);
          pendQ.delete(q);
          break;
        end
      end
      modelBusy = 1'b1;
    end
    if (handshake) begin
      rsp_t r;
      checkOutput("starts_per_txn", startCount, 1);
      r.id = expQ[0].id; r.prod = rsp_product; r.err = rsp_err; r.waited = rspCycles;
      rspLog.push_back(r);
      modelPtr   = (expQ[0].id + 1) % NUM_REQ;
      void'(expQ.pop_front());
      modelBusy  = 1'b0;
      startCount = 0;
      rspSeen    = 1'b0;
      rspCycles  = 0;
    end
  endtask

  // Reset with all requesters asserting; optionally the core then delivers
  // a stale done while the controller is already back in IDLE.
  task automatic doReset(bit lateDone);
    @(negedge clk);
    rst       = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b0;
    mul_done  = 1'b0;
    pendQ.delete(); expQ.delete();
    modelBusy = 0; modelPtr = 0; cd = 0; startCount = 0;
    rspSeen = 0; rspCycles = 0; holdLeft = 0;
    #1;
    checkOutput("ready_during_rst", req_ready, 0);
    @(negedge clk);
    checkOutput("rst_req_ready", req_ready, 0);
    checkOutput("rst_mul_start", mul_start, 0);
    checkOutput("rst_mul_a", mul_a, 0);
    checkOutput("rst_mul_b", mul_b, 0);
    checkOutput("rst_mul_mode", mul_mode, 0);
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_rsp_product", rsp_product, 0);
    checkOutput("rst_rsp_id", rsp_id, 0);
    checkOutput("rst_rsp_err", rsp_err, 0);
    rst       = 1'b0;
    req_valid = '0;
    if (lateDone) begin
      mul_done    = 1'b1;
      mul_product = 16'hBEEF;
      @(negedge clk);
      mul_done = 1'b0;
      for (int i = 0; i < 3; i++) begin
        checkOutput("late_done_rsp_valid", rsp_valid, 0);
        checkOutput("late_done_mul_start", mul_start, 0);
        checkOutput("late_done_rsp_product", rsp_product, 0);
        @(negedge clk);
      end
    end
  endtask

  task automatic runUntilDone(int budget, string name);
    int n;
    n = 0;
    while ((pendQ.size() > 0 || modelBusy) && n < budget) begin
      applyStimulus();
      n++;
    end
    checkOutput({name, "_completes"}, (pendQ.size() > 0 || modelBusy), 0);
    if (pendQ.size() > 0 || modelBusy) doReset(1'b0);
  endtask

  vec_t vecs[10];

  initial begin
    int n;
    vecs[0] = '{0, 8'hFF, 8'hFF, MODE_UU, 1, 0,  16'hFE01};
    vecs[1] = '{2, 8'h80, 8'h7F, MODE_SS, 2, 10, 16'hC080};
    vecs[2] = '{1, 8'hFE, 8'h03, MODE_SU, 3, 0,  16'hFFFA};
    vecs[3] = '{3, 8'hFF, 8'hFF, MODE_SS, 1, 0,  16'h0001};
    vecs[4] = '{0, 8'h80, 8'h80, MODE_SS, 4, 0,  16'h4000};
    vecs[5] = '{1, 8'hFF, 8'h02, MODE_US, 2, 0,  16'h01FE};
    vecs[6] = '{2, 8'h7F, 8'h80, MODE_US, 1, 2,  16'hC080};
    vecs[7] = '{3, 8'h80, 8'hFF, MODE_SU, 3, 0,  16'h8080};
    vecs[8] = '{0, 8'h00, 8'h9C, MODE_SS, 2, 0,  16'h0000};
    vecs[9] = '{1, 8'h7F, 8'h7F, MODE_UU, 5, 1,  16'h3F01};

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; req_mode = '0;
    rsp_ready = 1'b0; mul_done = 1'b0; mul_product = '0;
    doReset(1'b0);

    // Table-driven single transactions.
    for (int i = 0; i < 10; i++) begin
      pushJob(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].mode, vecs[i].lat);
      holdLeft = vecs[i].hold;
      runUntilDone(100, "vec");
      checkOutput("vec_count", rspLog.size(), i + 1);
      if (rspLog.size() > 0) begin
        checkOutput("vec_product", rspLog[rspLog.size()-1].prod, vecs[i].expProd);
        checkOutput("vec_id", rspLog[rspLog.size()-1].id, vecs[i].id);
        checkOutput("vec_waited", rspLog[rspLog.size()-1].waited, vecs[i].hold + 1);
      end
    end

    // Response held off while another requester waits: no new grant.
    rspLog.delete();
    holdLeft = 10;
    pushJob(2, 8'h80, 8'h7F, MODE_SS, 2);
    n = 0;
    while (!modelBusy && n < 20) begin
      applyStimulus();
      n++;
    end
    pushJob(0, 8'h05, 8'h06, MODE_UU, 1);
    runUntilDone(200, "hold");
    checkOutput("hold_count", rspLog.size(), 2);
    if (rspLog.size() == 2) begin
      checkOutput("hold_first_id", rspLog[0].id, 2);
      checkOutput("hold_first_product", rspLog[0].prod, 16'hC080);
      checkOutput("hold_first_waited", rspLog[0].waited, 11);
      checkOutput("hold_second_id", rspLog[1].id, 0);
      checkOutput("hold_second_product", rspLog[1].prod, 16'h001E);
    end

    // Reset while BUSY, stale done afterwards.
    pushJob(3, 8'h11, 8'h22, MODE_UU, 30);
    n = 0;
    while (startCount == 0 && n < 20) begin
      applyStimulus();
      n++;
    end
    checkOutput("midbusy_started", startCount, 1);
    applyStimulus();
    doReset(1'b1);

    // All four requesters continuously valid right after reset.
    rspLog.delete();
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        pushJob(k, 8'($urandom), 8'($urandom), 2'($urandom_range(0, 3)), 2);
      end
    end
    runUntilDone(400, "fair");
    checkOutput("fair_count", rspLog.size(), 2 * NUM_REQ);
    for (int i = 0; i < rspLog.size(); i++) begin
      checkOutput("fair_id_order", rspLog[i].id, i % NUM_REQ);
    end

`ifdef BOOTH_ARB_TIMEOUT_EN
    // Core never answers: abort after TIMEOUT_CYC BUSY cycles.
    rspLog.delete();
    coreMute = 1'b1;
    pushJob(1, 8'h12, 8'h34, MODE_UU, 1);
    runUntilDone(300, "timeout");
    coreMute = 1'b0;
    if (rspLog.size() > 0) begin
      checkOutput("timeout_err", rspLog[0].err, 1);
      checkOutput("timeout_product", rspLog[0].prod, 0);
    end
    // Done arriving on the timeout cycle wins.
    pushJob(2, 8'h12, 8'h34, MODE_UU, TIMEOUT_CYC);
    runUntilDone(300, "timeout_edge");
    checkOutput("timeout_edge_count", rspLog.size(), 2);
    if (rspLog.size() == 2) begin
      checkOutput("timeout_edge_err", rspLog[1].err, 0);
      checkOutput("timeout_edge_product", rspLog[1].prod, 16'h03A8);
    end
`endif

    // Randomized traffic with dropped valids and random rsp_ready.
    randomReady = 1'b1;
    randomDrop  = 1'b1;
    for (int it = 0; it < 30; it++) begin
      int nj;
      nj = $urandom_range(1, 3);
      for (int j = 0; j < nj; j++) begin
        pushJob($urandom_range(0, NUM_REQ - 1), 8'($urandom), 8'($urandom),
                2'($urandom_range(0, 3)), $urandom_range(1, 4));
      end
      n = $urandom_range(0, 6);
      for (int c = 0; c < n; c++) applyStimulus();
    end
    runUntilDone(4000, "random");
    randomReady = 1'b0;
    randomDrop  = 1'b0;

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
